// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - shared types and funct3 codes for the data-memory responder
package dmem_responder_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  funct3;
    logic [6:0]  pd;
    logic [4:0]  rob;
  } dmem_ld_req_t;

  // Halfword needs addr[0]==0, word needs addr[1:0]==0; byte accesses are never misaligned.
  function automatic logic is_misaligned(input logic [1:0] addr_lo, input logic [2:0] funct3);
    case (funct3)
      F3_H, F3_HU: return addr_lo[0];
      F3_W:        return addr_lo != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_load_fmt.sv
// rtl/dmem_load_fmt.sv - lane select and sign/zero extension of a loaded word
module dmem_load_fmt
  import dmem_responder_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo_i)
      2'd0:    byte_sel = word_i[7:0];
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      default: byte_sel = word_i[31:24];
    endcase
    half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];

    case (funct3_i)
      F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data_o = {24'b0, byte_sel};
      F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data_o = {16'b0, half_sel};
      F3_W:    data_o = word_i;
      default: data_o = 32'b0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - latency-modelled word data memory serving one load at a time plus store writebacks
// Optional misaligned-access checking when DMEM_MISALIGN_CHECK_EN is defined.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LOAD_LAT    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ld_req_valid,
  output logic        ld_req_ready,
  input  logic [31:0] ld_req_addr,
  input  logic [2:0]  ld_req_funct3,
  input  logic [6:0]  ld_req_pd,
  input  logic [4:0]  ld_req_rob,
  input  logic        st_wb_valid,
  input  logic [31:0] st_wb_addr,
  input  logic [31:0] st_wb_data,
  input  logic [2:0]  st_wb_funct3,
  input  logic        flush,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic [6:0]  resp_pd,
  output logic [4:0]  resp_rob,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0]  mem_q [DEPTH_WORDS];

  dmem_state_t  state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  dmem_ld_req_t req_q, req_d;
  logic         accept;

  logic [AW-1:0] st_idx;
  logic [3:0]    st_be;
  logic [31:0]   st_wdata;
  logic [31:0]   rd_word;
  logic [31:0]   ld_data;
  logic          unused_addr_bits;

  assign ld_req_ready = (state_q != BUSY);
  assign accept       = ld_req_valid && ld_req_ready && !flush;

  // IDLE and RESP behave identically for new requests, which is what allows back-to-back loads.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    case (state_q)
      BUSY: begin
        if (flush) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
        if (accept) begin
          req_d = '{addr: ld_req_addr, funct3: ld_req_funct3, pd: ld_req_pd, rob: ld_req_rob};
          if (LOAD_LAT == 1) begin
            state_d = RESP;
          end else begin
            state_d = BUSY;
            cnt_d   = 4'(LOAD_LAT - 1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
    end
  end

  // Narrow store data is replicated across lanes so the byte enables alone pick the target bytes.
  always_comb begin
    st_idx   = st_wb_addr[AW+1:2];
    st_be    = 4'b0000;
    st_wdata = st_wb_data;
    case (st_wb_funct3)
      F3_B: begin
        st_be    = 4'b0001 << st_wb_addr[1:0];
        st_wdata = {4{st_wb_data[7:0]}};
      end
      F3_H: begin
        st_be    = st_wb_addr[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{st_wb_data[15:0]}};
      end
      F3_W:    st_be = 4'b1111;
      default: st_be = 4'b0000;
    endcase
`ifdef DMEM_MISALIGN_CHECK_EN
    if (is_misaligned(st_wb_addr[1:0], st_wb_funct3)) st_be = 4'b0000;
`endif
  end

  always_ff @(posedge clk) begin
    if (st_wb_valid) begin
      for (int i = 0; i < 4; i++) begin
        if (st_be[i]) mem_q[st_idx][8*i +: 8] <= st_wdata[8*i +: 8];
      end
    end
  end

  // Combinational read in RESP: stores landing on the RESP-exit edge are not seen by this load.
  assign rd_word = mem_q[req_q.addr[AW+1:2]];

  dmem_load_fmt u_load_fmt (
    .word_i    (rd_word),
    .addr_lo_i (req_q.addr[1:0]),
    .funct3_i  (req_q.funct3),
    .data_o    (ld_data)
  );

  assign resp_valid = (state_q == RESP) && !flush;
  assign resp_data  = resp_valid ? ld_data   : 32'b0;
  assign resp_pd    = resp_valid ? req_q.pd  : 7'b0;
  assign resp_rob   = resp_valid ? req_q.rob : 5'b0;

`ifdef DMEM_MISALIGN_CHECK_EN
  assign resp_err = resp_valid && is_misaligned(req_q.addr[1:0], req_q.funct3);
`else
  assign resp_err = 1'b0;
`endif

  assign unused_addr_bits = ^{st_wb_addr[31:AW+2], req_q.addr[31:AW+2]};

endmodule
